// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle control FSM:
// state encodings, opcodes, strobe codes and the EXEC strobe bundle.
package multicycle_control_fsm_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_GRT  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_EQ   = 4'h3;
    localparam logic [3:0] OP_JALR = 4'h4;
    localparam logic [3:0] OP_LUI  = 4'h5;
    localparam logic [3:0] OP_JAL  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_WRI  = 4'hC;

    localparam logic [1:0] IMMGEN_I = 2'b00;
    localparam logic [1:0] IMMGEN_B = 2'b10;
    localparam logic [1:0] IMMGEN_U = 2'b11;

    localparam logic [1:0] ALUIN2_RS2 = 2'b00;
    localparam logic [1:0] ALUIN2_OFF = 2'b01;
    localparam logic [1:0] ALUIN2_IMM = 2'b10;

    localparam logic [1:0] ALUSRC_SUM = 2'b00;
    localparam logic [1:0] ALUSRC_GRT = 2'b01;
    localparam logic [1:0] ALUSRC_EQ  = 2'b10;

    // How an instruction leaves EXEC
    typedef enum logic [2:0] {
        C_ALU,
        C_JUMP,
        C_BRANCH,
        C_LOAD,
        C_STORE
    } op_class_t;

    typedef struct packed {
        logic [1:0] immgenop;
        logic       aluop;
        logic       aluin1;
        logic [1:0] aluin2;
        logic [1:0] alusrc;
    } strobe_t;

endpackage

// File: rtl/multicycle_control_fsm_opcode_strobe_decode.sv
// Pure combinational opcode decode: EXEC strobe vector and
// the class that steers the FSM out of EXEC and through MEM.
module opcode_strobe_decode
    import multicycle_control_fsm_pkg::*;
(
    input  logic [3:0] op,
    output strobe_t    strobes,
    output op_class_t  op_class
);

    // Opcode table; unlisted opcodes behave as rea (read to register)
    always_comb begin
        strobes  = '{IMMGEN_I, 1'b1, 1'b0, ALUIN2_RS2, ALUSRC_SUM};
        op_class = C_LOAD;
        unique case (op)
            OP_ADD: begin
                strobes  = '{IMMGEN_I, 1'b0, 1'b0, ALUIN2_RS2, ALUSRC_SUM};
                op_class = C_ALU;
            end
            OP_GRT: begin
                strobes  = '{IMMGEN_I, 1'b1, 1'b0, ALUIN2_RS2, ALUSRC_GRT};
                op_class = C_ALU;
            end
            OP_SUB: begin
                strobes  = '{IMMGEN_I, 1'b1, 1'b0, ALUIN2_RS2, ALUSRC_SUM};
                op_class = C_ALU;
            end
            OP_EQ: begin
                strobes  = '{IMMGEN_I, 1'b1, 1'b0, ALUIN2_RS2, ALUSRC_EQ};
                op_class = C_ALU;
            end
            OP_JALR: begin
                strobes  = '{IMMGEN_I, 1'b0, 1'b1, ALUIN2_OFF, ALUSRC_SUM};
                op_class = C_JUMP;
            end
            OP_LUI: begin
                strobes  = '{IMMGEN_U, 1'b1, 1'b0, ALUIN2_IMM, ALUSRC_SUM};
                op_class = C_ALU;
            end
            OP_JAL: begin
                strobes  = '{IMMGEN_B, 1'b0, 1'b1, ALUIN2_IMM, ALUSRC_SUM};
                op_class = C_JUMP;
            end
            OP_ADDI: begin
                strobes  = '{IMMGEN_I, 1'b0, 1'b0, ALUIN2_IMM, ALUSRC_SUM};
                op_class = C_ALU;
            end
            OP_LW: begin
                strobes  = '{IMMGEN_I, 1'b0, 1'b0, ALUIN2_IMM, ALUSRC_SUM};
                op_class = C_LOAD;
            end
            OP_SW: begin
                strobes  = '{IMMGEN_I, 1'b0, 1'b0, ALUIN2_IMM, ALUSRC_SUM};
                op_class = C_STORE;
            end
            OP_BNE: begin
                strobes  = '{IMMGEN_B, 1'b1, 1'b1, ALUIN2_RS2, ALUSRC_SUM};
                op_class = C_BRANCH;
            end
            OP_WRI: begin
                strobes  = '{IMMGEN_I, 1'b1, 1'b0, ALUIN2_RS2, ALUSRC_SUM};
                op_class = C_STORE;
            end
            default: begin
                strobes  = '{IMMGEN_I, 1'b1, 1'b0, ALUIN2_RS2, ALUSRC_SUM};
                op_class = C_LOAD;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB with
// memory ready handshake, wait timeout and a sticky trap state.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic            alu_zero,
    input  logic            mem_ready,
    output logic [1:0]      immgenop,
    output logic            aluop,
    output logic            aluin1,
    output logic [1:0]      aluin2,
    output logic [1:0]      alusrc,
    output logic            memread,
    output logic            memwrite,
    output logic            pcwrite,
    output logic            irwrite,
    output logic            regwrite,
    output logic            instr_done,
    output logic            trap,
    output logic [2:0]      state
);

    state_t          cur;
    state_t          nxt;
    logic [TO_W-1:0] cnt;
    logic            timed_out;
    logic            illegal;
    strobe_t         dec;
    op_class_t       cls;

    opcode_strobe_decode u_dec (
        .op       (op[3:0]),
        .strobes  (dec),
        .op_class (cls)
    );

    generate
        if (OP_W > 4) begin : g_wide
            assign illegal = |op[OP_W-1:4];
        end else begin : g_narrow
            assign illegal = 1'b0;
        end
    endgenerate

    assign timed_out = (cnt == TO_W'(TIMEOUT));
    assign state     = cur;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    // Wait counter: cleared on each state entry, counts idle memory cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (nxt != cur)
            cnt <= '0;
        else if (cur == S_FETCH || cur == S_MEM)
            cnt <= cnt + 1'b1;
    end

    // Next state and per-state strobes; reset forces every output low
    always_comb begin
        nxt        = cur;
        immgenop   = '0;
        aluop      = 1'b0;
        aluin1     = 1'b0;
        aluin2     = '0;
        alusrc     = '0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        pcwrite    = 1'b0;
        irwrite    = 1'b0;
        regwrite   = 1'b0;
        instr_done = 1'b0;
        trap       = 1'b0;
        unique case (cur)
            S_FETCH: begin
                memread = 1'b1;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    nxt     = S_DECODE;
                end else if (timed_out) begin
                    nxt = S_TRAP;
                end
            end
            S_DECODE: begin
                nxt = illegal ? S_TRAP : S_EXEC;
            end
            S_EXEC: begin
                immgenop = dec.immgenop;
                aluop    = dec.aluop;
                aluin1   = dec.aluin1;
                aluin2   = dec.aluin2;
                alusrc   = dec.alusrc;
                unique case (cls)
                    C_JUMP: begin
                        pcwrite = 1'b1;
                        nxt     = S_WB;
                    end
                    C_BRANCH: begin
                        pcwrite    = ~alu_zero;
                        instr_done = 1'b1;
                        nxt        = S_FETCH;
                    end
                    C_LOAD, C_STORE: nxt = S_MEM;
                    default:         nxt = S_WB;
                endcase
            end
            S_MEM: begin
                memread  = (cls == C_LOAD);
                memwrite = (cls == C_STORE);
                if (mem_ready) begin
                    instr_done = (cls == C_STORE);
                    nxt        = (cls == C_STORE) ? S_FETCH : S_WB;
                end else if (timed_out) begin
                    nxt = S_TRAP;
                end
            end
            S_WB: begin
                regwrite   = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                nxt = S_TRAP;
            end
        endcase
        if (reset) begin
            immgenop   = '0;
            aluop      = 1'b0;
            aluin1     = 1'b0;
            aluin2     = '0;
            alusrc     = '0;
            memread    = 1'b0;
            memwrite   = 1'b0;
            pcwrite    = 1'b0;
            irwrite    = 1'b0;
            regwrite   = 1'b0;
            instr_done = 1'b0;
            trap       = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed scoreboard bench for multicycle_control_fsm (OP_W=6).
// Expected output vectors are queued per cycle and compared on negedge.
module tb_multicycle_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       alu_zero;
    logic       mem_ready;
    logic [1:0] immgenop;
    logic       aluop;
    logic       aluin1;
    logic [1:0] aluin2;
    logic [1:0] alusrc;
    logic       memread;
    logic       memwrite;
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       instr_done;
    logic       trap;
    logic [2:0] state;

    int checks   = 0;
    int failures = 0;

    logic [17:0] sb[$];

    localparam logic [6:0] F_MR = 7'b1000000;
    localparam logic [6:0] F_MW = 7'b0100000;
    localparam logic [6:0] F_PW = 7'b0010000;
    localparam logic [6:0] F_IR = 7'b0001000;
    localparam logic [6:0] F_RW = 7'b0000100;
    localparam logic [6:0] F_DN = 7'b0000010;
    localparam logic [6:0] F_TR = 7'b0000001;

    multicycle_control_fsm #(
        .OP_W    (6),
        .TIMEOUT (15),
        .TO_W    (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .alu_zero   (alu_zero),
        .mem_ready  (mem_ready),
        .immgenop   (immgenop),
        .aluop      (aluop),
        .aluin1     (aluin1),
        .aluin2     (aluin2),
        .alusrc     (alusrc),
        .memread    (memread),
        .memwrite   (memwrite),
        .pcwrite    (pcwrite),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .instr_done (instr_done),
        .trap       (trap),
        .state      (state)
    );

    always #5 clk = ~clk;

    // {immgenop, aluop, aluin1, aluin2, alusrc} expected in EXEC
    function automatic logic [7:0] texp(input logic [3:0] o);
        case (o)
            4'h0:             return 8'b00_0_0_00_00;
            4'h1:             return 8'b00_1_0_00_01;
            4'h2:             return 8'b00_1_0_00_00;
            4'h3:             return 8'b00_1_0_00_10;
            4'h4:             return 8'b00_0_1_01_00;
            4'h5:             return 8'b11_1_0_10_00;
            4'h6:             return 8'b10_0_1_10_00;
            4'h8, 4'h9, 4'hA: return 8'b00_0_0_10_00;
            4'hB:             return 8'b10_1_1_00_00;
            default:          return 8'b00_1_0_00_00;
        endcase
    endfunction

    function automatic logic [17:0] mk(input logic [2:0] st,
                                       input logic [7:0] ex,
                                       input logic [6:0] fl);
        return {ex, fl, st};
    endfunction

    task automatic compare_now(input string tag);
        logic [17:0] got;
        logic [17:0] exp;
        got = {immgenop, aluop, aluin1, aluin2, alusrc,
               memread, memwrite, pcwrite, irwrite,
               regwrite, instr_done, trap, state};
        exp = sb.pop_front();
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue expectation, check at negedge
    task automatic cyc(input string tag, input logic [5:0] o,
                       input logic r, input logic z,
                       input logic [17:0] e);
        op        = o;
        mem_ready = r;
        alu_zero  = z;
        sb.push_back(e);
        @(negedge clk);
        compare_now(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        #2;
        sb.push_back(mk(3'd0, 8'h00, 7'h00));
        compare_now(tag);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Fetch + decode, zero-wait
    task automatic front(input string tag, input logic [5:0] o);
        cyc({tag, "_f"}, o, 1'b1, 1'b0, mk(3'd0, 8'h00, F_MR | F_IR | F_PW));
        cyc({tag, "_d"}, o, 1'b1, 1'b0, mk(3'd1, 8'h00, 7'h00));
    endtask

    // Register-writing instruction through EXEC and WB
    task automatic run_wb(input string tag, input logic [5:0] o,
                          input logic [6:0] xfl);
        front(tag, o);
        cyc({tag, "_x"}, o, 1'b1, 1'b0, mk(3'd2, texp(o[3:0]), xfl));
        cyc({tag, "_w"}, o, 1'b1, 1'b0, mk(3'd4, 8'h00, F_RW | F_DN));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        op        = '0;
        alu_zero  = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        sb.push_back(mk(3'd0, 8'h00, 7'h00));
        compare_now("reset_state");
        @(posedge clk);
        #1;
        reset = 1'b0;

        run_wb("add", 6'h00, 7'h00);
        run_wb("grt", 6'h01, 7'h00);
        run_wb("eq", 6'h03, 7'h00);
        run_wb("lui", 6'h05, 7'h00);
        run_wb("jal", 6'h06, F_PW);
        run_wb("jalr", 6'h04, F_PW);

        front("lw", 6'h09);
        cyc("lw_x", 6'h09, 1'b1, 1'b0, mk(3'd2, texp(4'h9), 7'h00));
        for (int i = 0; i < 3; i++)
            cyc("lw_mwait", 6'h09, 1'b0, 1'b0, mk(3'd3, 8'h00, F_MR));
        cyc("lw_mdone", 6'h09, 1'b1, 1'b0, mk(3'd3, 8'h00, F_MR));
        cyc("lw_w", 6'h09, 1'b0, 1'b0, mk(3'd4, 8'h00, F_RW | F_DN));

        front("sw", 6'h0A);
        cyc("sw_x", 6'h0A, 1'b1, 1'b0, mk(3'd2, texp(4'hA), 7'h00));
        cyc("sw_m", 6'h0A, 1'b1, 1'b0, mk(3'd3, 8'h00, F_MW | F_DN));

        front("bne0", 6'h0B);
        cyc("bne0_x", 6'h0B, 1'b1, 1'b0,
            mk(3'd2, texp(4'hB), F_PW | F_DN));
        front("bne1", 6'h0B);
        cyc("bne1_x", 6'h0B, 1'b1, 1'b1, mk(3'd2, texp(4'hB), F_DN));

        front("wri", 6'b001100);
        cyc("wri_x", 6'b001100, 1'b1, 1'b0, mk(3'd2, texp(4'hC), 7'h00));
        cyc("wri_mwait", 6'b001100, 1'b0, 1'b0, mk(3'd3, 8'h00, F_MW));
        cyc("wri_m", 6'b001100, 1'b1, 1'b0, mk(3'd3, 8'h00, F_MW | F_DN));

        front("rea", 6'h07);
        cyc("rea_x", 6'h07, 1'b1, 1'b0, mk(3'd2, texp(4'h7), 7'h00));
        cyc("rea_m", 6'h07, 1'b1, 1'b0, mk(3'd3, 8'h00, F_MR));
        cyc("rea_w", 6'h07, 1'b1, 1'b0, mk(3'd4, 8'h00, F_RW | F_DN));

        for (int i = 0; i < 15; i++)
            cyc("edge_fwait", 6'h00, 1'b0, 1'b0, mk(3'd0, 8'h00, F_MR));
        cyc("edge_f16", 6'h00, 1'b1, 1'b0,
            mk(3'd0, 8'h00, F_MR | F_IR | F_PW));
        cyc("edge_d", 6'h00, 1'b0, 1'b0, mk(3'd1, 8'h00, 7'h00));
        cyc("edge_x", 6'h00, 1'b0, 1'b0, mk(3'd2, texp(4'h0), 7'h00));
        cyc("edge_w", 6'h00, 1'b0, 1'b0, mk(3'd4, 8'h00, F_RW | F_DN));

        front("ill", 6'b010000);
        for (int i = 0; i < 3; i++)
            cyc("ill_trap", 6'b010000, 1'b1, 1'b0, mk(3'd7, 8'h00, F_TR));
        do_reset("ill_reset");

        for (int i = 0; i < 16; i++)
            cyc("to_fwait", 6'h00, 1'b0, 1'b0, mk(3'd0, 8'h00, F_MR));
        for (int i = 0; i < 3; i++)
            cyc("to_trap", 6'h00, 1'b1, 1'b0, mk(3'd7, 8'h00, F_TR));
        do_reset("to_reset");

        front("swr", 6'h0A);
        cyc("swr_x", 6'h0A, 1'b0, 1'b0, mk(3'd2, texp(4'hA), 7'h00));
        cyc("swr_m", 6'h0A, 1'b0, 1'b0, mk(3'd3, 8'h00, F_MW));
        do_reset("swr_reset");
        cyc("post_f", 6'h00, 1'b0, 1'b0, mk(3'd0, 8'h00, F_MR));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
